// File: rtl/xor_stim_pkg.sv
// Shared types and constants for the XOR DUT stimulus sequencer.
package xor_stim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_SETTLE,
    S_APPLY,
    S_FINRST,
    S_DONE
  } state_e;

  // One stimulus vector as driven onto the DUT pins.
  typedef struct packed {
    logic       sel;
    logic [1:0] a;
    logic [1:0] b;
  } vec_t;

  localparam int NUM_VEC = 4;
  localparam int VIDX_W  = 2;
  localparam int ERR_W   = 8;

  // Entry 0 sits in the low bits: {sel, a, b} per entry.
  localparam vec_t [NUM_VEC-1:0] VEC_TBL = {
    5'b1_10_00,   // v3
    5'b0_11_01,   // v2
    5'b1_00_11,   // v1
    5'b0_01_10    // v0
  };

endpackage

// File: rtl/xor_stim_chk.sv
// Response checker: delays the expected XOR values by LAT cycles, masks the
// first LAT cycles of every vector and counts mismatching cycles (saturating).
module xor_stim_chk
  import xor_stim_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             apply,
  input  logic             new_vec,
  input  logic [1:0]       a_drv,
  input  logic [1:0]       b_drv,
  input  logic             a_rsp,
  input  logic             b_rsp,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [2:0] LAT3 = 3'(LAT);

  logic [LAT:1][1:0] exp_q, exp_d;
  logic [2:0]        age_q, age_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              chk, mis;

  // Expected-value delay line plus per-vector age used for masking.
  always_comb begin
    exp_d    = exp_q;
    exp_d[1] = {^a_drv, ^b_drv};
    for (int i = 2; i <= LAT; i++) exp_d[i] = exp_q[i-1];
    if (new_vec)           age_d = '0;
    else if (age_q == '1)  age_d = age_q;
    else                   age_d = age_q + 3'd1;
    // Until LAT cycles into a vector the DUT still shows the previous one.
    chk = apply && (age_d >= LAT3);
    mis = chk && ({a_rsp, b_rsp} != exp_q[LAT]);
    if (clr)                       err_d = '0;
    else if (mis && err_q != '1)   err_d = err_q + 1'b1;
    else                           err_d = err_q;
  end

  // Checker state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      age_q <= '0;
      err_q <= '0;
    end else begin
      exp_q <= exp_d;
      age_q <= age_d;
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;

endmodule

// File: rtl/xor_stim_seq.sv
// Stimulus sequencer for the XOR DUT: resets it, lets it settle, walks the
// vector table, resets it again and reports pass/fail with an error count.
module xor_stim_seq
  import xor_stim_pkg::*;
#(
  parameter int RST_CYC    = 2,
  parameter int SETTLE_CYC = 5,
  parameter int HOLD_CYC   = 5,
  parameter int LAT        = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  output logic             Rstn_out,
  output logic [1:0]       A_out,
  output logic [1:0]       B_out,
  output logic             Sel_out,
  input  logic             A_xor_in,
  input  logic             B_xor_in,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] Err_cnt
);

  localparam int MAX_A = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int MAX_C = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int CNT_W = $clog2(MAX_C + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VIDX_W-1:0] vidx_q, vidx_d, vidx_nx;
  logic              rstn_q, rstn_d;
  logic [1:0]        a_q, a_d, b_q, b_d;
  logic              sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              apply_q, apply_d;
  logic              new_vec_q, new_vec_d;
  logic              clr;
  vec_t              nv;

  assign vidx_nx = vidx_q + 1'b1;

  // Next-state and next-output decode; outputs are computed for the state
  // being entered so every pin comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vidx_d    = vidx_q;
    rstn_d    = rstn_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    apply_d   = 1'b0;
    new_vec_d = 1'b0;
    clr       = 1'b0;
    nv        = VEC_TBL[0];
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (Start) begin
          state_d = S_RST;
          cnt_d   = CNT_W'(RST_CYC - 1);
          rstn_d  = 1'b0;
          a_d     = '0;
          b_d     = '0;
          sel_d   = 1'b0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      S_RST: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          rstn_d  = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d   = S_APPLY;
          cnt_d     = CNT_W'(HOLD_CYC - 1);
          vidx_d    = '0;
          nv        = VEC_TBL[0];
          a_d       = nv.a;
          b_d       = nv.b;
          sel_d     = nv.sel;
          apply_d   = 1'b1;
          new_vec_d = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_APPLY: begin
        apply_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(HOLD_CYC - 1);
          if (vidx_q == VIDX_W'(NUM_VEC - 1)) begin
            // Last vector done: pins keep v3 while the DUT is reset again.
            state_d = S_FINRST;
            rstn_d  = 1'b0;
            apply_d = 1'b0;
          end else begin
            vidx_d    = vidx_nx;
            nv        = VEC_TBL[vidx_nx];
            a_d       = nv.a;
            b_d       = nv.b;
            sel_d     = nv.sel;
            new_vec_d = 1'b1;
          end
        end else cnt_d = cnt_q - 1'b1;
      end
      S_FINRST: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (Err_cnt == '0);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; Reset wins over everything.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vidx_q    <= '0;
      rstn_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      apply_q   <= 1'b0;
      new_vec_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vidx_q    <= vidx_d;
      rstn_q    <= rstn_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      apply_q   <= apply_d;
      new_vec_q <= new_vec_d;
    end
  end

  xor_stim_chk #(.LAT(LAT)) u_chk (
    .clk     (Clock),
    .reset   (Reset),
    .clr     (clr),
    .apply   (apply_q),
    .new_vec (new_vec_q),
    .a_drv   (a_q),
    .b_drv   (b_q),
    .a_rsp   (A_xor_in),
    .b_rsp   (B_xor_in),
    .err_cnt (Err_cnt)
  );

  assign Rstn_out = rstn_q;
  assign A_out    = a_q;
  assign B_out    = b_q;
  assign Sel_out  = sel_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Pass     = pass_q;

endmodule
